// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that feeds one byte per frame from N_REQ requesters into a
// single serial transmitter (data_in/we/busy handshake).
module serial_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [7:0]               tx_data,
  output logic                     tx_we,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active
);

  localparam int GW = $clog2(N_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [N_REQ-1:0] ACK_LSB = N_REQ'(1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  logic          grant_ok;
  logic [7:0]    win_byte;

  // Scan upward from last_grant+1, wrapping; the first set request wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = GW'((32'(last_grant) + k) % N_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == GW'(i)) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  assign grant_ok = found && !tx_busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ok) state_next = ISSUE;
      ISSUE:   state_next = START;
      START:   if (tx_busy) state_next = DRAIN;
      DRAIN:   if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_data/grant_id only move on a grant, so they hold through the whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      tx_data    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_ok) begin
        last_grant <= winner;
        grant_id   <= winner;
        tx_data    <= win_byte;
      end
    end
  end

  assign tx_we  = (state == ISSUE);
  assign ack    = tx_we ? (ACK_LSB << grant_id) : '0;
  assign active = (state != IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed self-checking bench for serial_tx_arbiter with a behavioural
// serial transmitter (WAIT_DIV=3, start/8 data LSB-first/stop).
module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        force_busy;

  int checks = 0;
  int errors = 0;
  int stray  = 0;
  int extra  = 0;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.N_REQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_we    (tx_we),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active)
  );

  // Transmitter model: busy rises the cycle after we, each bit lasts 3 cycles.
  logic       m_busy = 1'b0;
  logic [9:0] m_sh   = '1;
  int         m_cnt  = 0;
  int         m_bit  = 0;
  logic       ser;

  always @(posedge clk) begin
    if (tx_we) begin
      m_sh   <= {1'b1, tx_data, 1'b0};
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_bit  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 2) begin
        m_cnt <= 0;
        if (m_bit == 9) m_busy <= 1'b0;
        else begin
          m_sh  <= m_sh >> 1;
          m_bit <= m_bit + 1;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign ser     = m_busy ? m_sh[0] : 1'b1;
  assign tx_busy = m_busy | force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for tx_we; gap = negedges from first busy-low sample to the strobe.
  task automatic wait_we(input int budget, output int gap, output bit ok);
    int n;
    int since;
    n = 0;
    since = -1;
    ok = 1'b0;
    gap = -1;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (tx_we) begin
        ok  = 1'b1;
        gap = since;
      end else begin
        if (ack != 4'b0000) stray++;
        if (tx_busy) since = 0;
        else if (since >= 0) since++;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && active) begin
      @(negedge clk);
      n++;
      if (tx_we || ack != 4'b0000) extra++;
    end
    chk("idle_timeout", {31'b0, active}, 32'd0);
  endtask

  initial begin
    int   gap;
    bit   ok;
    int   blk;
    logic [9:0] frame;
    int   order [0:6];
    int   tail  [0:1];

    order = '{0, 1, 2, 3, 0, 1, 2};
    tail  = '{0, 2};
    rst = 1'b0;
    req = '0;
    req_data = '0;
    force_busy = 1'b0;
    frame = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_active", {31'b0, active}, 32'd0);
    chk("rst_tx_we", {31'b0, tx_we}, 32'd0);
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd0);

    // V-1: single request, one-cycle latency, serial frame
    rst = 1'b1;
    req = 4'b0001;
    req_data = 32'h0000_00A5;
    @(negedge clk);
    chk("v1_tx_we", {31'b0, tx_we}, 32'd1);
    chk("v1_ack", {28'b0, ack}, 32'h1);
    chk("v1_tx_data", {24'b0, tx_data}, 32'hA5);
    chk("v1_grant", {30'b0, grant_id}, 32'd0);
    chk("v1_active", {31'b0, active}, 32'd1);
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) @(negedge clk);
      else repeat (3) @(negedge clk);
      frame[i] = ser;
    end
    chk("v1_frame", {22'b0, frame}, {22'b0, 10'b1101001010});
    wait_idle(100);

    // V-2: all requesting after a fresh reset -> 0,1,2,3,0,1,2
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    req_data = 32'h1312_1110;
    for (int j = 0; j < 7; j++) begin
      wait_we(200, gap, ok);
      chk("v2_we_timeout", {31'b0, ok}, 32'd1);
      chk("v2_grant", {30'b0, grant_id}, order[j]);
      chk("v2_ack", {28'b0, ack}, 32'd1 << order[j]);
      chk("v2_tx_data", {24'b0, tx_data}, 32'h10 + order[j]);
      if (j > 0) chk("v2_gap", gap, 32'd2);
    end

    // V-3: after grant 2, only 0 and 2 request -> wrap to 0, then 2
    req = 4'b0101;
    for (int j = 0; j < 2; j++) begin
      wait_we(200, gap, ok);
      chk("v3_we_timeout", {31'b0, ok}, 32'd1);
      chk("v3_grant", {30'b0, grant_id}, tail[j]);
      chk("v3_ack", {28'b0, ack}, 32'd1 << tail[j]);
      chk("v3_gap", gap, 32'd2);
    end
    req = 4'b0000;
    chk("v3_stray_ack", stray, 32'd0);
    wait_idle(200);

    // V-4: external busy in IDLE blocks the grant
    force_busy = 1'b1;
    req = 4'b0010;
    blk = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_we || ack != 4'b0000 || active) blk++;
    end
    chk("v4_blocked", blk, 32'd0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("v4_tx_we", {31'b0, tx_we}, 32'd1);
    chk("v4_grant", {30'b0, grant_id}, 32'd1);
    chk("v4_ack", {28'b0, ack}, 32'h2);
    req = 4'b0000;

    // V-5: reset while draining
    repeat (4) @(negedge clk);
    chk("v5_in_frame", {31'b0, active}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("v5_active", {31'b0, active}, 32'd0);
    chk("v5_tx_we", {31'b0, tx_we}, 32'd0);
    chk("v5_ack", {28'b0, ack}, 32'd0);
    chk("v5_grant", {30'b0, grant_id}, 32'd0);
    chk("v5_tx_data", {24'b0, tx_data}, 32'd0);
    rst = 1'b1;
    req = 4'b1000;
    wait_we(200, gap, ok);
    chk("v5_we_timeout", {31'b0, ok}, 32'd1);
    chk("v5_grant3", {30'b0, grant_id}, 32'd3);
    chk("v5_ack3", {28'b0, ack}, 32'h8);
    chk("v5_data3", {24'b0, tx_data}, 32'h13);
    req = 4'b0000;

    // V-6: request pulsed only during START is ignored
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    extra = 0;
    wait_idle(200);
    repeat (10) begin
      @(negedge clk);
      if (tx_we || ack != 4'b0000) extra++;
    end
    chk("v6_no_extra", extra, 32'd0);
    chk("v6_active", {31'b0, active}, 32'd0);
    chk("v6_data_hold", {24'b0, tx_data}, 32'h13);
    chk("v6_grant_hold", {30'b0, grant_id}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
